// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester IDs (which double as mem_sel values) and the fetch beat count.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_LO   = 2'd1,
    IF_HI   = 2'd2,
    LS_BEAT = 2'd3
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  localparam int FETCH_BEATS = 2;

endpackage

// File: rtl/mem_port_arbiter_rr2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that did not win last time. Winner is one-hot, indexed by REQ_* id.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_if,
  input  logic       req_ls,
  input  logic       last_winner,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    if (req_if && req_ls) begin
      winner = (last_winner == REQ_LS) ? 2'b01 : 2'b10;
    end else if (req_if) begin
      winner = 2'b01;
    end else if (req_ls) begin
      winner = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 8-bit memory port between instruction fetch (two beats) and
// load/store (one beat). Optional per-beat timeout enabled by ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW          = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [15:0]   if_instr,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [7:0]    ls_wdata,
  output logic          ls_gnt,
  output logic          ls_done,
  output logic [7:0]    ls_rdata,
  output logic          mem_sel,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ready,
  output logic          err
);

  // The high instruction byte sits one address above the low byte.
  localparam logic [AW-1:0] HI_OFS = AW'(FETCH_BEATS - 1);

  state_t          state, state_n;
  logic            last_winner, last_winner_n;
  logic [1:0]      winner;
  logic            abort;
  logic            if_gnt_n, if_done_n, ls_gnt_n, ls_done_n;
  logic            mem_sel_n, mem_req_n, mem_we_n;
  logic [15:0]     if_instr_n;
  logic [7:0]      ls_rdata_n, mem_wdata_n;
  logic [AW-1:0]   mem_addr_n;

  arb_rr2 u_rr (
    .req_if      (if_req),
    .req_ls      (ls_req),
    .last_winner (last_winner),
    .winner      (winner)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;

  // Counts idle cycles of the current beat; a beat starts at grant or on mem_ready.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || mem_ready) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign abort = (state != IDLE) && !mem_ready && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= abort;
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    state_n       = state;
    last_winner_n = last_winner;
    if_gnt_n      = if_gnt;
    ls_gnt_n      = ls_gnt;
    if_done_n     = 1'b0;
    ls_done_n     = 1'b0;
    if_instr_n    = if_instr;
    ls_rdata_n    = ls_rdata;
    mem_sel_n     = mem_sel;
    mem_req_n     = mem_req;
    mem_we_n      = mem_we;
    mem_addr_n    = mem_addr;
    mem_wdata_n   = mem_wdata;
    unique case (state)
      IDLE: begin
        if (winner[REQ_IF]) begin
          state_n       = IF_LO;
          last_winner_n = REQ_IF;
          if_gnt_n      = 1'b1;
          mem_req_n     = 1'b1;
          mem_sel_n     = REQ_IF;
          mem_we_n      = 1'b0;
          mem_addr_n    = if_addr;
        end else if (winner[REQ_LS]) begin
          state_n       = LS_BEAT;
          last_winner_n = REQ_LS;
          ls_gnt_n      = 1'b1;
          mem_req_n     = 1'b1;
          mem_sel_n     = REQ_LS;
          mem_we_n      = ls_we;
          mem_addr_n    = ls_addr;
          mem_wdata_n   = ls_wdata;
        end
      end
      IF_LO, IF_HI: begin
        if (mem_ready && state == IF_LO) begin
          if_instr_n[7:0] = mem_rdata;
          mem_addr_n      = mem_addr + HI_OFS;
          state_n         = IF_HI;
        end else if (mem_ready || abort) begin
          if_instr_n[15:8] = mem_rdata;
          if (abort) if_instr_n = 16'h0000;
          if_done_n = 1'b1;
          if_gnt_n  = 1'b0;
          mem_req_n = 1'b0;
          state_n   = IDLE;
        end
      end
      LS_BEAT: begin
        // A timeout reports a load result of zero.
        if (mem_ready || abort) begin
          if (abort) begin
            ls_rdata_n = 8'h00;
          end else if (!mem_we) begin
            ls_rdata_n = mem_rdata;
          end
          ls_done_n = 1'b1;
          ls_gnt_n  = 1'b0;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= REQ_LS;
      if_gnt      <= 1'b0;
      if_done     <= 1'b0;
      if_instr    <= 16'h0000;
      ls_gnt      <= 1'b0;
      ls_done     <= 1'b0;
      ls_rdata    <= 8'h00;
      mem_sel     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
    end else begin
      state       <= state_n;
      last_winner <= last_winner_n;
      if_gnt      <= if_gnt_n;
      if_done     <= if_done_n;
      if_instr    <= if_instr_n;
      ls_gnt      <= ls_gnt_n;
      ls_done     <= ls_done_n;
      ls_rdata    <= ls_rdata_n;
      mem_sel     <= mem_sel_n;
      mem_req     <= mem_req_n;
      mem_we      <= mem_we_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder with random wait
// states, per-requester expectation queues and a round-robin grant model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_gnt, if_done;
  logic [AW-1:0] if_addr;
  logic [15:0] if_instr;
  logic ls_req, ls_we, ls_gnt, ls_done;
  logic [AW-1:0] ls_addr;
  logic [7:0] ls_wdata, ls_rdata;
  logic mem_sel, mem_req, mem_we, mem_ready, err;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_instr(if_instr),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_sel(mem_sel), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {logic we; logic [7:0] rdata;} ls_exp_t;
  typedef struct {logic [AW-1:0] addr; logic we; logic [7:0] wdata;} ls_beat_t;

  logic [7:0]    mem [256];
  logic [15:0]   if_exp[$];
  ls_exp_t       ls_exp[$];
  logic [AW-1:0] if_beat_exp[$];
  ls_beat_t      ls_beat_exp[$];
  int            order_log[$];
  int            force_wait = 0;
  bit            spurious_en = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, ".if_gnt"}, if_gnt, 0);
    check_output({tag, ".if_done"}, if_done, 0);
    check_output({tag, ".if_instr"}, if_instr, 0);
    check_output({tag, ".ls_gnt"}, ls_gnt, 0);
    check_output({tag, ".ls_done"}, ls_done, 0);
    check_output({tag, ".ls_rdata"}, ls_rdata, 0);
    check_output({tag, ".mem_sel"}, mem_sel, 0);
    check_output({tag, ".mem_req"}, mem_req, 0);
    check_output({tag, ".mem_we"}, mem_we, 0);
    check_output({tag, ".mem_addr"}, mem_addr, 0);
    check_output({tag, ".mem_wdata"}, mem_wdata, 0);
    check_output({tag, ".err"}, err, 0);
  endtask

  // Issue a fetch; expected instruction is the two bytes at a and a+1 (mod 256).
  task automatic do_fetch(input logic [AW-1:0] a, input bit drop_early, output int lat);
    logic [AW-1:0] a1;
    a1 = a + 1'b1;
    if_exp.push_back({mem[a1], mem[a]});
    if_beat_exp.push_back(a);
    if_beat_exp.push_back(a1);
    if_addr = a;
    if_req  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (if_gnt) begin
        if_addr = AW'($urandom);
        if (drop_early) if_req = 1'b0;
      end
    end while (!if_done && lat < 200);
    if (!if_done) check_output("if_done_wait_expired", 0, 1);
    if_req = 1'b0;
  endtask

  task automatic do_ls(input logic we, input logic [AW-1:0] a, input logic [7:0] wd,
                       input bit drop_early, output int lat);
    ls_exp_t  e;
    ls_beat_t b;
    e.we = we;
    e.rdata = we ? 8'h00 : mem[a];
    ls_exp.push_back(e);
    b.addr = a; b.we = we; b.wdata = wd;
    ls_beat_exp.push_back(b);
    ls_we = we; ls_addr = a; ls_wdata = wd;
    ls_req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (ls_gnt) begin
        ls_addr  = AW'($urandom);
        ls_wdata = 8'($urandom);
        ls_we    = 1'($urandom);
        if (drop_early) ls_req = 1'b0;
      end
    end while (!ls_done && lat < 200);
    if (!ls_done) check_output("ls_done_wait_expired", 0, 1);
    ls_req = 1'b0;
  endtask

  // Memory responder: checks every beat against the issued requests and
  // answers with mem[] after a random (or forced) number of wait states.
  bit            in_beat = 1'b0;
  bit            spur = 1'b0;
  int            wait_left = 0;
  logic [AW-1:0] b_addr;
  logic          b_we, b_sel;
  logic [7:0]    b_wdata;
  logic [AW-1:0] ia;
  ls_beat_t      lb;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mem_ready = 1'b0;
        in_beat = 1'b0;
        spur = 1'b0;
        continue;
      end
      if (mem_ready) begin
        mem_ready = 1'b0;
        if (!spur) in_beat = 1'b0;
        spur = 1'b0;
      end
      if (mem_req && !in_beat) begin
        in_beat = 1'b1;
        b_addr = mem_addr; b_we = mem_we; b_sel = mem_sel; b_wdata = mem_wdata;
        wait_left = (force_wait >= 0) ? force_wait : $urandom_range(0, 2);
        if (mem_sel == REQ_IF) begin
          check_output("beat.if_gnt", if_gnt, 1);
          check_output("beat.if_we", mem_we, 0);
          if (if_beat_exp.size() == 0) begin
            check_output("beat.if_unexpected", 1, 0);
          end else begin
            ia = if_beat_exp.pop_front();
            check_output("beat.if_addr", mem_addr, ia);
          end
        end else begin
          check_output("beat.ls_gnt", ls_gnt, 1);
          if (ls_beat_exp.size() == 0) begin
            check_output("beat.ls_unexpected", 1, 0);
          end else begin
            lb = ls_beat_exp.pop_front();
            check_output("beat.ls_addr", mem_addr, lb.addr);
            check_output("beat.ls_we", mem_we, lb.we);
            if (lb.we) check_output("beat.ls_wdata", mem_wdata, lb.wdata);
          end
        end
      end else if (in_beat) begin
        check_output("hold.mem_req", mem_req, 1);
        check_output("hold.mem_addr", mem_addr, b_addr);
        check_output("hold.mem_we", mem_we, b_we);
        check_output("hold.mem_sel", mem_sel, b_sel);
        if (b_we) check_output("hold.mem_wdata", mem_wdata, b_wdata);
      end
      if (in_beat) begin
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr];
        end else begin
          wait_left--;
          mem_rdata = 8'($urandom);
        end
      end else if (spurious_en && $urandom_range(0, 3) == 0) begin
        mem_ready = 1'b1;
        spur = 1'b1;
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Monitor: pops expectations on done pulses and checks the round-robin rule
  // using the requests seen in the previous (idle) cycle.
  logic    p_if_req = 1'b0, p_ls_req = 1'b0, p_rst = 1'b1, p_idle = 1'b1;
  logic    exp_last = REQ_LS;
  logic [15:0] ie;
  ls_exp_t le;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if_done) begin
          order_log.push_back(0);
          check_output("if_done.err", err, 0);
          if (if_exp.size() == 0) begin
            check_output("if_done_unexpected", 1, 0);
          end else begin
            ie = if_exp.pop_front();
            check_output("if_done.instr", if_instr, ie);
          end
        end
        if (ls_done) begin
          order_log.push_back(1);
          check_output("ls_done.err", err, 0);
          if (ls_exp.size() == 0) begin
            check_output("ls_done_unexpected", 1, 0);
          end else begin
            le = ls_exp.pop_front();
            if (!le.we) check_output("ls_done.rdata", ls_rdata, le.rdata);
          end
        end
        check_output("gnt_overlap", if_gnt && ls_gnt, 0);
        if (p_rst) begin
          check_output("after_reset.gnt", {if_gnt, ls_gnt}, 2'b00);
          exp_last = REQ_LS;
        end else if (p_idle) begin
          if (p_if_req && (!p_ls_req || exp_last == REQ_LS)) begin
            check_output("rr.grant_if", {if_gnt, ls_gnt}, 2'b10);
            exp_last = REQ_IF;
          end else if (p_ls_req) begin
            check_output("rr.grant_ls", {if_gnt, ls_gnt}, 2'b01);
            exp_last = REQ_LS;
          end else begin
            check_output("rr.no_grant", {if_gnt, ls_gnt}, 2'b00);
          end
        end
      end
      p_rst    = rst;
      p_if_req = if_req;
      p_ls_req = ls_req;
      p_idle   = !if_gnt && !ls_gnt;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus_random(input bit is_fetch, input int count);
    int lat, gap;
    for (int i = 0; i < count; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      if (is_fetch) do_fetch(AW'($urandom), 1'($urandom), lat);
      else          do_ls(1'($urandom), AW'($urandom), 8'($urandom), 1'($urandom), lat);
    end
  endtask

  int lat, l1, l2, l3, n;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h34;
    mem[8'h11] = 8'h12;
    force_wait = 0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Uncontended fetch, zero wait states.
    do_fetch(8'h10, 1'b0, lat);
    check_output("fetch.latency", lat, 3);
    check_output("fetch.instr", if_instr, 16'h1234);

    // Store with two wait states, then a zero-wait load.
    force_wait = 2;
    do_ls(1'b1, 8'h80, 8'hA5, 1'b0, lat);
    check_output("store.latency", lat, 4);
    force_wait = 0;
    do_ls(1'b0, 8'h22, 8'h00, 1'b0, lat);
    check_output("load.latency", lat, 2);
    check_output("load.rdata", ls_rdata, mem[8'h22]);

    // Fetch whose high byte wraps to address 0.
    do_fetch(8'hFF, 1'b0, lat);
    check_output("wrap.instr", if_instr, {mem[8'h00], mem[8'hFF]});

    // Reset while the second fetch beat is on the bus.
    if_beat_exp.push_back(8'h40);
    if_beat_exp.push_back(8'h41);
    if_addr = 8'h40;
    if_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #3;
      n++;
    end while (!(mem_req && mem_addr == 8'h41) && n < 20);
    check_output("midfetch.reached_hi", n < 20, 1);
    rst = 1'b1;
    if_req = 1'b0;
    @(posedge clk); #3;
    check_all_zero("reset_mid_fetch");
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests right after reset: IF, LS, then IF again.
    order_log.delete();
    fork
      begin do_fetch(8'h50, 1'b0, l1); do_fetch(8'h60, 1'b0, l2); end
      begin do_ls(1'b0, 8'h70, 8'h00, 1'b0, l3); end
    join
    repeat (2) begin @(posedge clk); #1; end
    check_output("tie.count", order_log.size(), 3);
    if (order_log.size() == 3) begin
      check_output("tie.first", order_log[0], 0);
      check_output("tie.second", order_log[1], 1);
      check_output("tie.third", order_log[2], 0);
    end

    // Random traffic with wait states, spurious ready and early request drops.
    force_wait = -1;
    spurious_en = 1'b1;
    fork
      apply_stimulus_random(1'b1, 20);
      apply_stimulus_random(1'b0, 20);
    join
    spurious_en = 1'b0;
    repeat (10) begin @(posedge clk); #1; end

    check_output("drain.if_exp", if_exp.size(), 0);
    check_output("drain.ls_exp", ls_exp.size(), 0);
    check_output("drain.if_beats", if_beat_exp.size(), 0);
    check_output("drain.ls_beats", ls_beat_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single 8-bit memory port between the instruction-fetch unit (IF) and the load/store unit (LS).
- Drives the memory address/data 2:1 select (mem_sel) and sequences the transfers:
  - a fetch is two byte beats, because a 16-bit instruction crosses the 8-bit bus;
  - a load or store is one beat.
- Sits between the IF/LS units and the memory interface, next to the address/data selection muxes.

Parameters:
- AW, 8, memory address width in bits.
- TIMEOUT_CYC, 15, maximum cycles to wait for mem_ready per beat. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  AW  fetch address of the low byte
- if_gnt  out  1  high while a fetch owns the port
- if_done  out  1  one-cycle pulse; if_instr valid in the same cycle
- if_instr  out  16  fetched instruction, {byte@addr+1, byte@addr}
- ls_req  in  1  load/store request; held high until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  AW  load/store address
- ls_wdata  in  8  store data
- ls_gnt  out  1  high while LS owns the port
- ls_done  out  1  one-cycle pulse; ls_rdata valid in the same cycle for loads
- ls_rdata  out  8  load data
- mem_sel  out  1  datapath mux select: 0 = fetch path, 1 = LS path
- mem_req  out  1  memory beat request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  beat address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data; valid when mem_ready = 1
- mem_ready  in  1  beat complete
- err  out  1  timeout flag; pulses together with the done pulse

Behaviour:
- Clock and reset: one clock domain. Synchronous, active-high reset; all outputs are registered.
- Reset state:
  - every output = 0, including if_instr = 16'h0000 and ls_rdata = 8'h00;
  - state = IDLE;
  - last_winner = LS, so the first tie goes to IF.
- States: IDLE, IF_LO, IF_HI, LS_BEAT.
- IDLE:
  - Samples the requests. A lone request wins. If both are high, the requester that is not last_winner wins.
  - On the next edge: enter IF_LO or LS_BEAT, and assert the matching gnt, mem_req and mem_sel.
  - Latency from request to first mem_req is 1 cycle.
- Capture at grant: the winner's address, ls_we and ls_wdata are captured at the grant edge. Later changes to the inputs are ignored until done.
- IF_LO:
  - mem_addr = captured if_addr; mem_we = 0.
  - On mem_ready: latch mem_rdata into if_instr[7:0], then go to IF_HI.
- IF_HI:
  - mem_addr = captured if_addr + 1, modulo 2^AW (8'hFF wraps to 8'h00).
  - On mem_ready: latch if_instr[15:8], pulse if_done on the next cycle, then go to IDLE.
- LS_BEAT:
  - mem_we = captured ls_we; mem_wdata = captured ls_wdata.
  - On mem_ready: latch ls_rdata (load), pulse ls_done, then go to IDLE.
- Release:
  - gnt and mem_req drop in the same cycle as the done pulse.
  - mem_sel holds its last value while IDLE.
  - last_winner updates at each grant.
- Minimum spacing: one IDLE cycle between transactions. Best-case fetch = 4 cycles from request to done; best-case load/store = 3 cycles.
- Boundary conditions:
  - mem_ready outside IF_LO, IF_HI or LS_BEAT is ignored.
  - A requester dropping req mid-transaction does not abort it; the transaction completes and done still pulses.
  - A request that arrives during the other requester's transaction waits. It wins at the next IDLE because of round-robin.
  - rst mid-transaction returns to IDLE at once with no done pulse; partially captured data is cleared.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - a per-beat counter (width clog2(TIMEOUT_CYC+1)) clears at every beat start;
  - if TIMEOUT_CYC cycles pass without mem_ready, the transaction aborts;
  - the matching done pulses with err = 1, data forced to 0 (if_instr = 16'h0000 or ls_rdata = 8'h00), and the block returns to IDLE.
- Undefined:
  - the block waits indefinitely for mem_ready;
  - err is tied to 0 and the counter is absent.

Decomposition:
- Shared package/include:
  - state encoding (IDLE = 0, IF_LO = 1, IF_HI = 2, LS_BEAT = 3);
  - requester IDs (REQ_IF = 0, REQ_LS = 1), which also serve as the mem_sel values;
  - FETCH_BEATS = 2.
- Sub-module arb_rr2: 2-way round-robin picker. Inputs: two requests and last_winner. Output: a one-hot winner.
- The FSM, capture registers and timeout stay in mem_port_arbiter.

Test Plan:
- Fetch, no contention: if_req = 1, if_addr = 8'h10; memory returns 8'h34 at 8'h10 and 8'h12 at 8'h11 with 0 wait states → if_done at cycle 4, if_instr = 16'h1234, mem_sel = 0 throughout.
- Tie twice: if_req and ls_req held high from reset → IF served first, then LS, then IF. gnt pulses never overlap.
- Store with 2 wait states: ls_we = 1, ls_addr = 8'h80, ls_wdata = 8'hA5 → mem_we = 1, mem_addr = 8'h80, mem_wdata = 8'hA5 held for 3 cycles; ls_done one cycle after mem_ready.
- Address wrap: if_addr = 8'hFF → second beat mem_addr = 8'h00; if_instr = {byte@00, byte@FF}.
- Reset mid-fetch: assert rst during IF_HI → next cycle all outputs are 0 and no if_done pulses. A new if_req after reset is granted normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC = 15: LS load, mem_ready never asserted → ls_done and err pulse 15 cycles after the beat starts, ls_rdata = 8'h00; a pending if_req is granted next.
